snes_bus_sync: RTL and testbench

Front-end stage feeding the cheat/hook engine and other SNES-side consumers. It synchronises the asynchronous SNES bus pins into the clk domain and glitch-filters the control pins. It produces the single-cycle strobes SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start and SNES_reset_strobe, plus registered address and data. It also snoops CPU register writes to derive pad_latch ($4016) and snes_ajr ($4200).

---
 rtl/snes_bus_pkg.sv | 30 +++
 rtl/sync_filter.sv | 49 ++++
 rtl/snes_bus_sync.sv | 147 ++++++++++++++
 tb/tb_snes_bus_sync.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_bus_pkg.sv
// Shared constants for the SNES bus front-end: snooped register addresses,
// filter counter width, control-pin idle levels and pin-vector indices.
package snes_bus_pkg;

  localparam logic [15:0] REG_JOYSER0  = 16'h4016;
  localparam logic [15:0] REG_NMITIMEN = 16'h4200;

  // Wide enough for FILTER_LEN up to 7.
  localparam int FILTER_CNT_W = 3;

  localparam logic IDLE_RD      = 1'b1;
  localparam logic IDLE_WR      = 1'b1;
  localparam logic IDLE_RESET   = 1'b1;
  localparam logic IDLE_CPU_CLK = 1'b0;

  // Bit positions of the control pins inside the filtered-level vector.
  localparam int PIN_RD  = 0;
  localparam int PIN_WR  = 1;
  localparam int PIN_RST = 2;
  localparam int PIN_CLK = 3;
  localparam int NUM_PINS = 4;

  localparam logic [NUM_PINS-1:0] IDLE_VEC = {IDLE_CPU_CLK, IDLE_RESET, IDLE_WR, IDLE_RD};

  // CPU register writes are snooped only in banks with A22 clear.
  function automatic logic is_snoop(input logic [23:0] addr, input logic [15:0] reg_addr);
    return (addr[22] == 1'b0) && (addr[15:0] == reg_addr);
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchroniser followed by a debounce filter. The filtered level only
// follows the synced pin after it has disagreed for FILTER_LEN consecutive clks.
module sync_filter
  import snes_bus_pkg::*;
#(
  parameter int   FILTER_LEN = 3,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level
);

  localparam logic [FILTER_CNT_W-1:0] CNT_MAX = FILTER_CNT_W'(FILTER_LEN - 1);

  logic                    s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d;
  logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while synced and filtered levels disagree.
  always_comb begin
    s1_d  = pin_in;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_MAX) lvl_d = s2_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // Sync stages restart at the idle level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= IDLE_LEVEL;
      s2_q  <= IDLE_LEVEL;
      lvl_q <= IDLE_LEVEL;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = lvl_q;

endmodule

// File: rtl/snes_bus_sync.sv
// SNES bus front-end: synchronises and filters bus pins, emits single-clk
// strobes, and snoops $4016/$4200 writes for pad_latch and snes_ajr.
// Optional: define BUS_SYNC_CYCLE_COUNT_EN to add a 16-bit CPU cycle counter.
module snes_bus_sync
  import snes_bus_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] SNES_ADDR_IN,
  input  logic [7:0]  SNES_PA_IN,
  input  logic [7:0]  SNES_DATA_IN,
  input  logic        SNES_READ,
  input  logic        SNES_WRITE,
  input  logic        SNES_CPU_CLK,
  input  logic        SNES_RESET,
  output logic [23:0] SNES_ADDR,
  output logic [7:0]  SNES_PA,
  output logic [7:0]  SNES_DATA,
  output logic        SNES_rd_strobe,
  output logic        SNES_wr_strobe,
  output logic        SNES_cycle_start,
  output logic        SNES_reset_strobe,
  output logic        pad_latch,
  output logic        snes_ajr
`ifdef BUS_SYNC_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  logic [NUM_PINS-1:0] pins, lvl;
  logic [NUM_PINS-1:0] prev_q, prev_d;
  logic [23:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
  logic [7:0]  pa_s1_q, pa_s1_d, pa_s2_q, pa_s2_d;
  logic [7:0]  data_s1_q, data_s1_d, data_s2_q, data_s2_d, data_q, data_d;
  logic        rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic        cs_q, cs_d, rst_stb_q, rst_stb_d;
  logic        pad_q, pad_d, ajr_q, ajr_d;

  assign pins = {SNES_CPU_CLK, SNES_RESET, SNES_WRITE, SNES_READ};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_filt
    sync_filter #(
      .FILTER_LEN (FILTER_LEN),
      .IDLE_LEVEL (IDLE_VEC[i])
    ) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_in (pins[i]),
      .level  (lvl[i])
    );
  end

  // Edge detect on filtered levels, data capture and register snooping.
  always_comb begin
    addr_s1_d = SNES_ADDR_IN;
    addr_s2_d = addr_s1_q;
    pa_s1_d   = SNES_PA_IN;
    pa_s2_d   = pa_s1_q;
    data_s1_d = SNES_DATA_IN;
    data_s2_d = data_s1_q;
    prev_d    = lvl;
    // Track the bus while /WR is low so the last low-phase value survives the rising edge.
    data_d    = lvl[PIN_WR] ? data_q : data_s2_q;
    // Bus strobes are gated off while the console is held in reset.
    rd_stb_d  = prev_q[PIN_RD] & ~lvl[PIN_RD] & lvl[PIN_RST];
    wr_stb_d  = ~prev_q[PIN_WR] & lvl[PIN_WR] & lvl[PIN_RST];
    cs_d      = ~prev_q[PIN_CLK] & lvl[PIN_CLK];
    rst_stb_d = ~prev_q[PIN_RST] & lvl[PIN_RST];
    pad_d     = pad_q;
    ajr_d     = ajr_q;
    if (rst_stb_q) begin
      pad_d = 1'b0;
      ajr_d = 1'b0;
    end else if (wr_stb_q) begin
      if (is_snoop(addr_s2_q, REG_JOYSER0))  pad_d = data_q[0];
      if (is_snoop(addr_s2_q, REG_NMITIMEN)) ajr_d = data_q[0];
    end
  end

  // Output and pipeline registers; prev levels restart idle with the filters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      pa_s1_q   <= '0;
      pa_s2_q   <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      data_q    <= '0;
      prev_q    <= IDLE_VEC;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      cs_q      <= 1'b0;
      rst_stb_q <= 1'b0;
      pad_q     <= 1'b0;
      ajr_q     <= 1'b0;
    end else begin
      addr_s1_q <= addr_s1_d;
      addr_s2_q <= addr_s2_d;
      pa_s1_q   <= pa_s1_d;
      pa_s2_q   <= pa_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      data_q    <= data_d;
      prev_q    <= prev_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      cs_q      <= cs_d;
      rst_stb_q <= rst_stb_d;
      pad_q     <= pad_d;
      ajr_q     <= ajr_d;
    end
  end

  assign SNES_ADDR         = addr_s2_q;
  assign SNES_PA           = pa_s2_q;
  assign SNES_DATA         = data_q;
  assign SNES_rd_strobe    = rd_stb_q;
  assign SNES_wr_strobe    = wr_stb_q;
  assign SNES_cycle_start  = cs_q;
  assign SNES_reset_strobe = rst_stb_q;
  assign pad_latch         = pad_q;
  assign snes_ajr          = ajr_q;

`ifdef BUS_SYNC_CYCLE_COUNT_EN
  logic [15:0] count_q, count_d;

  // Console reset clears the count even if a cycle_start lands in the same clk.
  always_comb begin
    count_d = count_q;
    if (rst_stb_q) count_d = '0;
    else if (cs_q) count_d = count_q + 16'd1;
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign cycle_count = count_q;
`endif

endmodule

// File: tb/tb_snes_bus_sync.sv
// Scoreboard bench for snes_bus_sync (FILTER_LEN=3): stimulus pushes expected
// strobes with their arrival cycle; a negedge monitor pops and compares.
module tb_snes_bus_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] SNES_ADDR_IN;
  logic [7:0]  SNES_PA_IN, SNES_DATA_IN;
  logic        SNES_READ, SNES_WRITE, SNES_CPU_CLK, SNES_RESET;
  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_PA, SNES_DATA;
  logic        SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start, SNES_reset_strobe;
  logic        pad_latch, snes_ajr;
`ifdef BUS_SYNC_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  snes_bus_sync #(.FILTER_LEN(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .SNES_ADDR_IN      (SNES_ADDR_IN),
    .SNES_PA_IN        (SNES_PA_IN),
    .SNES_DATA_IN      (SNES_DATA_IN),
    .SNES_READ         (SNES_READ),
    .SNES_WRITE        (SNES_WRITE),
    .SNES_CPU_CLK      (SNES_CPU_CLK),
    .SNES_RESET        (SNES_RESET),
    .SNES_ADDR         (SNES_ADDR),
    .SNES_PA           (SNES_PA),
    .SNES_DATA         (SNES_DATA),
    .SNES_rd_strobe    (SNES_rd_strobe),
    .SNES_wr_strobe    (SNES_wr_strobe),
    .SNES_cycle_start  (SNES_cycle_start),
    .SNES_reset_strobe (SNES_reset_strobe),
    .pad_latch         (pad_latch),
    .snes_ajr          (snes_ajr)
`ifdef BUS_SYNC_CYCLE_COUNT_EN
    ,
    .cycle_count       (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t rd_q[$], wr_q[$], rst_q[$];
  exp_t e;
  int   cyc = 0;
  int   cs_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (SNES_cycle_start) cs_cnt++;
      if (SNES_rd_strobe) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
          chk("rd_addr", 32'(SNES_ADDR), 32'(e.addr));
        end
      end
      if (SNES_wr_strobe) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          chk("wr_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
          chk("wr_addr", 32'(SNES_ADDR), 32'(e.addr));
          chk("wr_data", 32'(SNES_DATA), 32'(e.data));
        end
      end
      if (SNES_reset_strobe) begin
        if (rst_q.size() == 0) chk("rst_unexpected", 32'd1, 32'd0);
        else begin
          e = rst_q.pop_front();
          chk("rst_cycle", e.cyc == cyc ? 32'd1 : 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int kind, input int at, input logic [23:0] a, input logic [7:0] d);
    exp_t x;
    x.cyc = at; x.addr = a; x.data = d;
    case (kind)
      0: rd_q.push_back(x);
      1: wr_q.push_back(x);
      default: rst_q.push_back(x);
    endcase
  endtask

  // Write cycle: /WR low for 'low' clks; strobe expected 6 clks after release.
  task automatic do_wr(input logic [23:0] a, input logic [7:0] d, input int low, input bit expect_stb);
    SNES_ADDR_IN = a;
    SNES_DATA_IN = d;
    step(3);
    SNES_WRITE = 1'b0;
    step(low);
    SNES_WRITE = 1'b1;
    if (expect_stb) push(1, cyc + 6, a, d);
    step(10);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, 32'(SNES_ADDR), 32'd0);
    chk({nm, "_pa"}, 32'(SNES_PA), 32'd0);
    chk({nm, "_data"}, 32'(SNES_DATA), 32'd0);
    chk({nm, "_strobes"}, 32'({SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start, SNES_reset_strobe}), 32'd0);
    chk({nm, "_pad"}, 32'(pad_latch), 32'd0);
    chk({nm, "_ajr"}, 32'(snes_ajr), 32'd0);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_rd_pending"}, 32'(rd_q.size()), 32'd0);
    chk({nm, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    chk({nm, "_rst_pending"}, 32'(rst_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    SNES_ADDR_IN = 24'h0; SNES_PA_IN = 8'h0; SNES_DATA_IN = 8'h0;
    SNES_READ = 1'b1; SNES_WRITE = 1'b1; SNES_CPU_CLK = 1'b0; SNES_RESET = 1'b1;
    #22;
    chk_zero("reset");
    step(1);
    rst_n = 1'b1;
    step(3);

    // Read: one strobe 6 clks after /RD falls, address already synced.
    SNES_ADDR_IN = 24'h00FFEA;
    SNES_PA_IN   = 8'h21;
    step(3);
    SNES_READ = 1'b0;
    push(0, cyc + 6, 24'h00FFEA, 8'h00);
    step(10);
    SNES_READ = 1'b1;
    step(10);
    chk("pa_sync", 32'(SNES_PA), 32'h21);
    chk_empty("read");

    // Read fall and write rise filtered in the same clk: both strobes together.
    SNES_ADDR_IN = 24'h001234;
    SNES_DATA_IN = 8'h5A;
    step(3);
    SNES_WRITE = 1'b0;
    step(6);
    SNES_WRITE = 1'b1;
    SNES_READ  = 1'b0;
    push(0, cyc + 6, 24'h001234, 8'h00);
    push(1, cyc + 6, 24'h001234, 8'h5A);
    step(10);
    SNES_READ = 1'b1;
    step(10);
    chk_empty("simul");

    // $4016 snoop, including a bank with bit23 set.
    do_wr(24'h004016, 8'h01, 6, 1'b1);
    chk("pad_set", 32'(pad_latch), 32'd1);
    do_wr(24'h804016, 8'h00, 6, 1'b1);
    chk("pad_clr", 32'(pad_latch), 32'd0);
    do_wr(24'h004016, 8'h01, 6, 1'b1);
    chk("pad_set2", 32'(pad_latch), 32'd1);

    // Short /WR glitch: no strobe, no snoop, data register untouched.
    do_wr(24'h004016, 8'h00, 2, 1'b0);
    chk("glitch_pad", 32'(pad_latch), 32'd1);
    chk("glitch_data", 32'(SNES_DATA), 32'h01);
    chk_empty("glitch");

    // $4200 snoop qualifies only with A22 clear.
    do_wr(24'h404200, 8'h81, 6, 1'b1);
    chk("ajr_bit22", 32'(snes_ajr), 32'd0);
    do_wr(24'h004200, 8'h81, 6, 1'b1);
    chk("ajr_set", 32'(snes_ajr), 32'd1);

    // /RESET held 20 clks with a read inside it (suppressed), then release.
    SNES_RESET = 1'b0;
    step(8);
    SNES_READ = 1'b0;
    step(6);
    SNES_READ = 1'b1;
    step(6);
    SNES_RESET = 1'b1;
    push(2, cyc + 6, 24'h0, 8'h0);
    step(10);
    chk("rst_ajr", 32'(snes_ajr), 32'd0);
    chk("rst_pad", 32'(pad_latch), 32'd0);
    chk_empty("reset_pin");

    // CPU clock, 12-clk period, 100 periods.
    chk("cs_before", 32'(cs_cnt), 32'd0);
    for (int p = 0; p < 100; p++) begin
      SNES_CPU_CLK = 1'b1;
      step(6);
      SNES_CPU_CLK = 1'b0;
      step(6);
    end
    step(10);
    chk("cs_count", 32'(cs_cnt), 32'd100);
`ifdef BUS_SYNC_CYCLE_COUNT_EN
    chk("cycle_count", 32'(cycle_count), 32'd100);
`endif

    // rst_n while filtered /WR is low: outputs clear now, no strobe afterwards.
    do_wr(24'h004016, 8'h01, 6, 1'b1);
    chk("pad_pre_abort", 32'(pad_latch), 32'd1);
    SNES_ADDR_IN = 24'h004016;
    SNES_DATA_IN = 8'h01;
    SNES_PA_IN   = 8'h00;
    step(3);
    SNES_WRITE = 1'b0;
    step(8);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
`ifdef BUS_SYNC_CYCLE_COUNT_EN
    chk("abort_cycle_count", 32'(cycle_count), 32'd0);
`endif
    SNES_WRITE = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("abort_pad", 32'(pad_latch), 32'd0);
    chk_empty("abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
